// File: rtl/sound_i2s_pkg.sv
// Shared types, constants and the channel re-encoding helper for the I2S receive path.
package sound_i2s_pkg;

  typedef enum logic [1:0] {
    ALIGN = 2'd0,
    SKIP  = 2'd1,
    RUN   = 2'd2
  } rx_state_t;

  localparam int I2S_ACTIVE_BITS       = 16;
  localparam int I2S_SLOT_BITS_DEFAULT = 32;

  // Unsigned channels drop the slot's sign bit so a tx->rx chain returns the original value.
  function automatic logic [15:0] map_channel(input logic [15:0] field,
                                              input logic        signed_out,
                                              input int          width);
    logic [15:0] mask;
    mask = 16'((17'h1 << width) - 17'h1);
    if (signed_out) begin
      map_channel = field >> (16 - width);
    end else begin
      map_channel = (field >> (15 - width)) & mask;
    end
  endfunction

endpackage

// File: rtl/sound_i2s_if.sv
// Parallel audio sample bus produced by the I2S receiver.
interface sound_i2s_if #(
  parameter int CHANNEL_WIDTH = 15
);
  logic [CHANNEL_WIDTH-1:0] audio_l;
  logic [CHANNEL_WIDTH-1:0] audio_r;
  logic                     audio_valid;
  logic                     locked;
  logic                     frame_error;

  modport master (output audio_l, output audio_r, output audio_valid,
                  output locked, output frame_error);
  modport slave  (input audio_l, input audio_r, input audio_valid,
                  input locked, input frame_error);
endinterface

// File: rtl/sound_i2s_rx_sync.sv
// Two-flop synchroniser for the asynchronous I2S pins plus an SCLK history flop for edge detection.
module i2s_rx_sync (
  input  logic clk_74a,
  input  logic reset,
  input  logic i2s_sclk,
  input  logic i2s_lrck,
  input  logic i2s_data,
  output logic sclk_rise,
  output logic lrck_s,
  output logic data_s
);
  // Bit order in the vectors: [2]=sclk, [1]=lrck, [0]=data.
  logic [2:0] meta_q, meta_d;
  logic [2:0] sync_q, sync_d;
  logic       hist_q, hist_d;

  // Next-state for the synchroniser chain.
  always_comb begin
    meta_d = {i2s_sclk, i2s_lrck, i2s_data};
    sync_d = meta_q;
    hist_d = sync_q[2];
  end

  // Synchroniser and history registers.
  always_ff @(posedge clk_74a) begin
    if (reset) begin
      meta_q <= 3'b000;
      sync_q <= 3'b000;
      hist_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      hist_q <= hist_d;
    end
  end

  assign sclk_rise = sync_q[2] & ~hist_q;
  assign lrck_s    = sync_q[1];
  assign data_s    = sync_q[0];
endmodule

// File: rtl/sound_i2s_rx.sv
// I2S receiver: 64-SCLK stereo frames into parallel left/right samples in the clk_74a domain.
module sound_i2s_rx
  import sound_i2s_pkg::*;
#(
  parameter int CHANNEL_WIDTH  = 15,
  parameter int SIGNED_OUTPUT  = 0,
  parameter int SLOT_BITS      = I2S_SLOT_BITS_DEFAULT,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic        clk_74a,
  input  logic        reset,
  input  logic        i2s_sclk,
  input  logic        i2s_lrck,
  input  logic        i2s_data,
  sound_i2s_if.master aud
);
  localparam int CW = $clog2(SLOT_BITS + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  if (CHANNEL_WIDTH < 1 || CHANNEL_WIDTH > 16 ||
      (CHANNEL_WIDTH == 16 && SIGNED_OUTPUT == 0) || SLOT_BITS < 17) begin : g_bad_params
    $error("sound_i2s_rx: illegal CHANNEL_WIDTH/SIGNED_OUTPUT/SLOT_BITS combination");
  end

  logic sclk_rise, lrck_s, data_s, lr_edge;

  i2s_rx_sync u_sync (
    .clk_74a  (clk_74a),
    .reset    (reset),
    .i2s_sclk (i2s_sclk),
    .i2s_lrck (i2s_lrck),
    .i2s_data (i2s_data),
    .sclk_rise(sclk_rise),
    .lrck_s   (lrck_s),
    .data_s   (data_s)
  );

  rx_state_t               state_q, state_d;
  logic                    lrck_prev_q, lrck_prev_d;
  logic [CW-1:0]           bit_cnt_q, bit_cnt_d;
  logic [TW-1:0]           tmo_q, tmo_d;
  logic [15:0]             shift_q, shift_d;
  logic [15:0]             hold_q, hold_d;
  logic [CHANNEL_WIDTH-1:0] audio_l_q, audio_l_d, audio_r_q, audio_r_d;
  logic                    valid_q, valid_d, locked_q, locked_d, ferr_q, ferr_d;

  assign lr_edge = sclk_rise && (lrck_s != lrck_prev_q);

  // Framing FSM, bit counter, shift/hold registers and timeout watchdog.
  always_comb begin
    state_d     = state_q;
    lrck_prev_d = lrck_prev_q;
    bit_cnt_d   = bit_cnt_q;
    tmo_d       = tmo_q;
    shift_d     = shift_q;
    hold_d      = hold_q;
    audio_l_d   = audio_l_q;
    audio_r_d   = audio_r_q;
    locked_d    = locked_q;
    valid_d     = 1'b0;
    ferr_d      = 1'b0;

    if (sclk_rise) begin
      tmo_d       = '0;
      lrck_prev_d = lrck_s;
      if (lr_edge) begin
        bit_cnt_d = '0;
      end else begin
        if (bit_cnt_q != CW'(SLOT_BITS)) begin
          bit_cnt_d = bit_cnt_q + CW'(1);
        end else begin
          bit_cnt_d = bit_cnt_q;
        end
        // The edge bit belongs to the previous slot, so only the following 16 are kept.
        if (bit_cnt_q < CW'(I2S_ACTIVE_BITS)) begin
          shift_d = {shift_q[14:0], data_s};
        end else begin
          shift_d = shift_q;
        end
      end

      if (lr_edge) begin
        case (state_q)
          ALIGN: state_d = SKIP;
          SKIP: begin
            if (!lrck_s) begin
              state_d = RUN;
              shift_d = 16'h0000;
            end else begin
              state_d = SKIP;
            end
          end
          RUN: begin
            shift_d = 16'h0000;
            if (bit_cnt_q == CW'(SLOT_BITS - 1)) begin
              if (lrck_s) begin
                hold_d   = shift_q;
                locked_d = 1'b1;
              end else begin
                audio_l_d = CHANNEL_WIDTH'(map_channel(hold_q, SIGNED_OUTPUT != 0, CHANNEL_WIDTH));
                audio_r_d = CHANNEL_WIDTH'(map_channel(shift_q, SIGNED_OUTPUT != 0, CHANNEL_WIDTH));
                valid_d   = 1'b1;
              end
            end else begin
              ferr_d   = 1'b1;
              locked_d = 1'b0;
              state_d  = SKIP;
            end
          end
          default: state_d = ALIGN;
        endcase
      end else begin
        state_d = state_q;
      end
    end else begin
      if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
        locked_d = 1'b0;
        state_d  = ALIGN;
      end else begin
        tmo_d = tmo_q + TW'(1);
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk_74a) begin
    if (reset) begin
      state_q     <= ALIGN;
      lrck_prev_q <= 1'b0;
      bit_cnt_q   <= '0;
      tmo_q       <= '0;
      shift_q     <= 16'h0000;
      hold_q      <= 16'h0000;
      audio_l_q   <= '0;
      audio_r_q   <= '0;
      valid_q     <= 1'b0;
      locked_q    <= 1'b0;
      ferr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      lrck_prev_q <= lrck_prev_d;
      bit_cnt_q   <= bit_cnt_d;
      tmo_q       <= tmo_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      audio_l_q   <= audio_l_d;
      audio_r_q   <= audio_r_d;
      valid_q     <= valid_d;
      locked_q    <= locked_d;
      ferr_q      <= ferr_d;
    end
  end

  assign aud.audio_l     = audio_l_q;
  assign aud.audio_r     = audio_r_q;
  assign aud.audio_valid = valid_q;
  assign aud.locked      = locked_q;
  assign aud.frame_error = ferr_q;
endmodule

// File: tb/tb_sound_i2s_rx.sv
// Drives an I2S stream into an unsigned 15-bit and a signed 16-bit receiver and checks both against a slot-level model.
module tb_sound_i2s_rx;
  localparam int HALF = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sclk = 1'b1;
  logic lrck = 1'b0;
  logic sdata = 1'b0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sound_i2s_if #(.CHANNEL_WIDTH(15)) a15 ();
  sound_i2s_if #(.CHANNEL_WIDTH(16)) a16 ();

  sound_i2s_rx #(.CHANNEL_WIDTH(15), .SIGNED_OUTPUT(0)) dut15 (
    .clk_74a(clk), .reset(rst), .i2s_sclk(sclk), .i2s_lrck(lrck), .i2s_data(sdata), .aud(a15.master));
  sound_i2s_rx #(.CHANNEL_WIDTH(16), .SIGNED_OUTPUT(1)) dut16 (
    .clk_74a(clk), .reset(rst), .i2s_sclk(sclk), .i2s_lrck(lrck), .i2s_data(sdata), .aud(a16.master));

  int ntests = 0;
  int nfail  = 0;

  // Slot-level reference: 0 = hunting any LRCK change, 1 = waiting for a left start, 2 = running.
  int          m_phase, m_len, m_ncap, m_err;
  bit          m_prev_lr, m_locked;
  logic [15:0] m_cap, m_hold, m_last_l, m_last_r;
  logic [31:0] exp_q[$];

  int          n_valid = 0, n_err = 0, last_vcyc = 0, prev_vcyc = 0, left_rise_cyc = 0;
  logic [31:0] e;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    ntests++;
    assert (obs === exp_v) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_len = 0; m_ncap = 0; m_prev_lr = 1'b0; m_locked = 1'b0;
    m_cap = 16'h0; m_hold = 16'h0; m_last_l = 16'h0; m_last_r = 16'h0;
  endtask

  task automatic model_period(input bit v, input bit d);
    if (v != m_prev_lr) begin
      case (m_phase)
        0: m_phase = 1;
        1: m_phase = (v == 1'b0) ? 2 : 1;
        default: begin
          if (m_len == 32) begin
            if (v) begin
              m_hold = m_cap; m_locked = 1'b1;
            end else begin
              exp_q.push_back({m_hold, m_cap});
              m_last_l = m_hold; m_last_r = m_cap;
            end
          end else begin
            m_err++; m_locked = 1'b0; m_phase = 1;
          end
        end
      endcase
      m_len = 1; m_cap = 16'h0; m_ncap = 0;
    end else begin
      m_len++;
      if (m_ncap < 16) begin
        m_cap = {m_cap[14:0], d}; m_ncap++;
      end
    end
    m_prev_lr = v;
  endtask

  task automatic period(input bit lr, input bit d);
    @(negedge clk); sclk = 1'b0; lrck = lr; sdata = d;
    repeat (HALF) @(negedge clk);
    sclk = 1'b1;
    if (lr != m_prev_lr && lr == 1'b0) left_rise_cyc = cyc;
    model_period(lr, d);
    repeat (HALF - 1) @(negedge clk);
  endtask

  task automatic send_slot(input bit lr, input logic [15:0] s, input int len, input bit ones_pad);
    bit d;
    for (int k = 0; k < len; k++) begin
      if (k >= 1 && k <= 16) d = s[16-k];
      else d = ones_pad ? 1'b1 : 1'($urandom_range(0, 1));
      period(lr, d);
    end
  endtask

  task automatic send_frame(input logic [15:0] l, input logic [15:0] r, input int llen, input bit ones_pad);
    send_slot(1'b0, l, llen, ones_pad);
    send_slot(1'b1, r, 32, ones_pad);
  endtask

  task automatic send_random(input int n);
    for (int i = 0; i < n; i++) send_frame(16'($urandom), 16'($urandom), 32, 1'b0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_l15"}, 32'(a15.audio_l), 0);
    check({tag, "_r15"}, 32'(a15.audio_r), 0);
    check({tag, "_l16"}, 32'(a16.audio_l), 0);
    check({tag, "_r16"}, 32'(a16.audio_r), 0);
    check({tag, "_valid"}, 32'({a15.audio_valid, a16.audio_valid}), 0);
    check({tag, "_locked"}, 32'({a15.locked, a16.locked}), 0);
    check({tag, "_ferr"}, 32'({a15.frame_error, a16.frame_error}), 0);
  endtask

  task automatic checkpoint(input string tag);
    repeat (8) @(negedge clk);
    check({tag, "_pending"}, exp_q.size(), 0);
    check({tag, "_locked15"}, 32'(a15.locked), 32'(m_locked));
    check({tag, "_locked16"}, 32'(a16.locked), 32'(m_locked));
    check({tag, "_ferr_cnt"}, n_err, m_err);
    check({tag, "_l15"}, 32'(a15.audio_l), 32'(m_last_l[14:0]));
    check({tag, "_r15"}, 32'(a15.audio_r), 32'(m_last_r[14:0]));
    check({tag, "_l16"}, 32'(a16.audio_l), 32'(m_last_l));
    check({tag, "_r16"}, 32'(a16.audio_r), 32'(m_last_r));
  endtask

  // Output monitor: every valid pulse must match the next modelled sample pair.
  always @(negedge clk) begin
    if (a15.audio_valid || a16.audio_valid) begin
      check("valid_pair", 32'(a16.audio_valid), 32'(a15.audio_valid));
      check("valid_expected", 32'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("mon_l15", 32'(a15.audio_l), 32'(e[30:16]));
        check("mon_r15", 32'(a15.audio_r), 32'(e[14:0]));
        check("mon_l16", 32'(a16.audio_l), 32'(e[31:16]));
        check("mon_r16", 32'(a16.audio_r), 32'(e[15:0]));
        check("latency_le6", 32'((cyc - left_rise_cyc) <= 6), 1);
      end
      prev_vcyc = last_vcyc;
      last_vcyc = cyc;
      n_valid++;
    end
    if (a15.frame_error || a16.frame_error) begin
      check("ferr_pair", 32'(a16.frame_error), 32'(a15.frame_error));
      n_err++;
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nv, d;
    m_err = 0;
    model_reset();
    repeat (4) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;

    // Locking and steady streaming, including signed extremes.
    send_frame(16'h1234, 16'h7ABC, 32, 1'b0);
    send_frame(16'h1234, 16'h7ABC, 32, 1'b0);
    send_frame(16'h8001, 16'h7FFF, 32, 1'b0);
    send_random(5);
    checkpoint("steady");
    d = last_vcyc - prev_vcyc;
    check("valid_interval_ok", 32'(d >= 1023 && d <= 1025), 1);

    // Short left slot: one error, lock lost, then recovery.
    send_frame(16'($urandom), 16'($urandom), 31, 1'b0);
    checkpoint("short_slot");
    send_random(3);
    checkpoint("short_resume");

    // SCLK stops mid right slot.
    send_slot(1'b0, 16'($urandom), 32, 1'b0);
    send_slot(1'b1, 16'($urandom), 10, 1'b0);
    nv = n_valid;
    repeat (240) @(negedge clk);
    check("tmo_locked_before", 32'(a15.locked), 1);
    repeat (50) @(negedge clk);
    check("tmo_locked_after", 32'(a15.locked), 0);
    check("tmo_no_valid", n_valid, nv);
    model_timeout_i();
    checkpoint("tmo_idle");
    nv = n_valid;
    send_random(3);
    checkpoint("tmo_recover");
    check("tmo_one_valid", n_valid - nv, 1);

    // Reset in the middle of a left slot.
    send_slot(1'b0, 16'($urandom), 10, 1'b0);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    check_zero("mid_reset");
    model_reset();
    send_random(3);
    checkpoint("post_reset");

    // Extreme data with pad bits forced high.
    send_frame(16'h0000, 16'h7FFF, 32, 1'b1);
    send_frame(16'($urandom), 16'($urandom), 32, 1'b1);
    checkpoint("pad_ones");
    check("pad_l15", 32'(a15.audio_l), 0);
    check("pad_r15", 32'(a15.audio_r), 32'h7FFF);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

  task automatic model_timeout_i();
    m_phase = 0; m_locked = 1'b0;
  endtask
endmodule
